// File: rtl/ads1292_filter_pkg.sv
// Shared state encoding, engine indices and scaling helpers for the ADS1292
// float filter chain.
package ads1292_filter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    localparam int WORD_W  = 32;
    localparam int ENG_I2F = 0;

    // The f2i engine always sits directly after the last filter engine.
    function automatic int eng_f2i(input int n_flt);
        return n_flt + 1;
    endfunction

    function automatic int scale_pad(input int data_w);
        return WORD_W - data_w;
    endfunction

    // Half an output LSB, expressed in the 32-bit engine word.
    function automatic logic [WORD_W-1:0] scale_round(input int data_w);
        return (data_w < WORD_W) ? (WORD_W'(1) << (WORD_W - 1 - data_w)) : '0;
    endfunction

endpackage

// File: rtl/ads1292_filter_scaler.sv
// Rounds a 32-bit f2i result down to DATA_W bits, saturating on overflow.
module ads1292_filter_scaler
    import ads1292_filter_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic [WORD_W-1:0] word,
    output logic [DATA_W-1:0] sample
);

    localparam int                PAD     = scale_pad(DATA_W);
    localparam logic [WORD_W-1:0] ROUND   = scale_round(DATA_W);
    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [WORD_W-1:0] sum;
    logic              ovf;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        sum = word + ROUND;
        ovf = (word[WORD_W-1] == ROUND[WORD_W-1]) && (sum[WORD_W-1] != word[WORD_W-1]);
        if (ovf) begin
            sample = word[WORD_W-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sample = DATA_W'(sum >> PAD);
        end
    end

endmodule

// File: rtl/ads1292_filter_chain.sv
// Sequences each channel of an ADS1292 frame through i2f, N_FLT float filter
// engines and f2i, with per-engine timeout and overrun detection.
module ads1292_filter_chain
    import ads1292_filter_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DATA_W  = 24,
    parameter int N_FLT   = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                                      i_CLK,
    input  logic                                      i_RST,
    input  logic [N_CH*DATA_W-1:0]                    i_DATA,
    input  logic                                      i_DATA_VALID,
    output logic [N_CH*DATA_W-1:0]                    o_FILT_DATA,
    output logic                                      o_FILT_VALID,
    input  logic                                      i_FILT_ACK,
    input  logic [N_FLT-1:0]                          i_BYPASS,
    output logic [WORD_W-1:0]                         o_ENG_X,
    output logic [N_FLT+1:0]                          o_ENG_X_VALID,
    input  logic [N_FLT+1:0]                          i_ENG_X_READY,
    input  logic [(N_FLT+2)*WORD_W-1:0]               i_ENG_Y,
    input  logic [N_FLT+1:0]                          i_ENG_Y_VALID,
    output logic [N_FLT+1:0]                          o_ENG_Y_ACK,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] o_ENG_CH,
    output logic                                      o_OVERRUN,
    output logic                                      o_TIMEOUT,
    input  logic                                      i_ERR_CLR
);

    localparam int N_ENG   = N_FLT + 2;
    localparam int ENG_F2I = eng_f2i(N_FLT);
    localparam int ENG_W   = $clog2(N_ENG);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W   = $clog2(TIMEOUT + 1);
    localparam int PAD     = scale_pad(DATA_W);

    state_t                 state_q;
    logic [N_CH*DATA_W-1:0] frame_q;
    logic [N_CH*DATA_W-1:0] slots_q;
    logic [N_FLT-1:0]       bypass_q;
    logic [CH_W-1:0]        ch_q;
    logic [ENG_W-1:0]       eng_q;
    logic [WORD_W-1:0]      operand_q;
    logic [CNT_W-1:0]       wait_q;
    logic                   overrun_q;
    logic                   timeout_q;

    logic [N_ENG-1:0]  eng_sel;
    logic [WORD_W-1:0] eng_y;
    logic [ENG_W-1:0]  next_eng;
    logic [CH_W-1:0]   next_ch;
    logic [WORD_W-1:0] next_ch_operand;
    logic              busy;
    logic              step_done;
    logic              timed_out;
    logic              ch_done;
    logic              last_ch;
    logic [DATA_W-1:0] scaled;
    logic [DATA_W-1:0] slot_val;

    ads1292_filter_scaler #(
        .DATA_W (DATA_W)
    ) u_scaler (
        .word   (eng_y),
        .sample (scaled)
    );

    always_comb begin
        eng_sel          = '0;
        eng_sel[eng_q]   = 1'b1;
        eng_y            = i_ENG_Y[int'(eng_q)*WORD_W +: WORD_W];
        // Lowest-numbered non-bypassed filter above the current engine, else f2i.
        next_eng = ENG_W'(ENG_F2I);
        for (int k = N_FLT; k >= 1; k--) begin
            if (k > int'(eng_q) && !bypass_q[k-1]) begin
                next_eng = ENG_W'(k);
            end
        end
        busy      = (state_q == ISSUE) || (state_q == WAIT);
        step_done = ((state_q == ISSUE) && i_ENG_X_READY[eng_q]) ||
                    ((state_q == WAIT)  && i_ENG_Y_VALID[eng_q]);
        timed_out = busy && !step_done && (wait_q == CNT_W'(TIMEOUT - 1));
        ch_done   = ((state_q == WAIT) && i_ENG_Y_VALID[eng_q] && (eng_q == ENG_W'(ENG_F2I))) ||
                    timed_out;
        slot_val  = timed_out ? '0 : scaled;
        last_ch   = (ch_q == CH_W'(N_CH - 1));
        next_ch   = ch_q + 1'b1;
        next_ch_operand = WORD_W'(frame_q[int'(next_ch)*DATA_W +: DATA_W]) << PAD;
    end

    always_ff @(posedge i_CLK) begin
        // NOTE: frame and slot storage is reset too, so a reset never exposes stale samples.
        if (i_RST) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            slots_q   <= '0;
            bypass_q  <= '0;
            ch_q      <= '0;
            eng_q     <= '0;
            operand_q <= '0;
            wait_q    <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // A new error event wins over a same-cycle clear.
            if (i_DATA_VALID && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end else if (i_ERR_CLR) begin
                overrun_q <= 1'b0;
            end
            if (timed_out) begin
                timeout_q <= 1'b1;
            end else if (i_ERR_CLR) begin
                timeout_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (i_DATA_VALID) begin
                        frame_q   <= i_DATA;
                        bypass_q  <= i_BYPASS;
                        ch_q      <= '0;
                        eng_q     <= ENG_W'(ENG_I2F);
                        operand_q <= WORD_W'(i_DATA[DATA_W-1:0]) << PAD;
                        wait_q    <= '0;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    if (ch_done) begin
                        slots_q[int'(ch_q)*DATA_W +: DATA_W] <= slot_val;
                        wait_q <= '0;
                        if (last_ch) begin
                            state_q <= FINISH;
                        end else begin
                            ch_q      <= next_ch;
                            eng_q     <= ENG_W'(ENG_I2F);
                            operand_q <= next_ch_operand;
                            state_q   <= ISSUE;
                        end
                    end else if (step_done && (state_q == ISSUE)) begin
                        wait_q  <= wait_q + 1'b1;
                        state_q <= WAIT;
                    end else if (step_done) begin
                        operand_q <= eng_y;
                        eng_q     <= next_eng;
                        wait_q    <= '0;
                        state_q   <= ISSUE;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                FINISH: begin
                    if (i_FILT_ACK) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Strobes are gated by reset so an abandoned frame never emits a pulse.
    assign o_ENG_X_VALID = ((state_q == ISSUE) && !i_RST) ? (eng_sel & i_ENG_X_READY) : '0;
    assign o_ENG_Y_ACK   = ((state_q == WAIT)  && !i_RST) ? (eng_sel & i_ENG_Y_VALID) : '0;
    assign o_FILT_DATA   = slots_q;
    assign o_FILT_VALID  = (state_q == FINISH);
    assign o_ENG_X       = operand_q;
    assign o_ENG_CH      = ch_q;
    assign o_OVERRUN     = overrun_q;
    assign o_TIMEOUT     = timeout_q;

endmodule

// File: tb/tb_ads1292_filter_chain.sv
// Self-checking bench: echo engine models, frame scoreboard, strobe monitor.
`timescale 1ns/1ps
module tb_ads1292_filter_chain;

    localparam int N_CH    = 2;
    localparam int DATA_W  = 24;
    localparam int N_FLT   = 3;
    localparam int TIMEOUT = 1023;
    localparam int N_ENG   = N_FLT + 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [N_CH*DATA_W-1:0] data = '0;
    logic                   data_valid = 1'b0;
    logic [N_CH*DATA_W-1:0] filt_data;
    logic                   filt_valid;
    logic                   filt_ack = 1'b0;
    logic [N_FLT-1:0]       bypass = '0;
    logic [31:0]            eng_x;
    logic [N_ENG-1:0]       eng_x_valid;
    logic [N_ENG-1:0]       eng_x_ready;
    logic [N_ENG*32-1:0]    eng_y;
    logic [N_ENG-1:0]       eng_y_valid;
    logic [N_ENG-1:0]       eng_y_ack;
    logic [0:0]             eng_ch;
    logic                   overrun;
    logic                   tmo;
    logic                   err_clr = 1'b0;

    always #5 clk = ~clk;

    ads1292_filter_chain #(
        .N_CH    (N_CH),
        .DATA_W  (DATA_W),
        .N_FLT   (N_FLT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .i_CLK         (clk),
        .i_RST         (rst),
        .i_DATA        (data),
        .i_DATA_VALID  (data_valid),
        .o_FILT_DATA   (filt_data),
        .o_FILT_VALID  (filt_valid),
        .i_FILT_ACK    (filt_ack),
        .i_BYPASS      (bypass),
        .o_ENG_X       (eng_x),
        .o_ENG_X_VALID (eng_x_valid),
        .i_ENG_X_READY (eng_x_ready),
        .i_ENG_Y       (eng_y),
        .i_ENG_Y_VALID (eng_y_valid),
        .o_ENG_Y_ACK   (eng_y_ack),
        .o_ENG_CH      (eng_ch),
        .o_OVERRUN     (overrun),
        .o_TIMEOUT     (tmo),
        .i_ERR_CLR     (err_clr)
    );

    // Zero-wait echo engines: result is valid the cycle after the strobe.
    bit               drop_mode = 1'b0;
    bit               force_en  = 1'b0;
    logic [31:0]      force_val = '0;
    logic [N_ENG-1:0] pend;
    logic [31:0]      yreg [N_ENG];

    always @(posedge clk) begin
        for (int e = 0; e < N_ENG; e++) begin
            if (rst) begin
                pend[e] <= 1'b0;
                yreg[e] <= '0;
            end else if (eng_x_valid[e]) begin
                if (!(drop_mode && e == 1 && eng_ch == 1'b0)) begin
                    pend[e] <= 1'b1;
                    yreg[e] <= (force_en && e == N_ENG - 1) ? force_val : eng_x;
                end
            end else if (eng_y_ack[e]) begin
                pend[e] <= 1'b0;
            end
        end
    end

    always_comb begin
        eng_y = '0;
        for (int e = 0; e < N_ENG; e++) begin
            eng_y[e*32 +: 32] = yreg[e];
        end
    end
    assign eng_y_valid = pend;
    assign eng_x_ready = '1;

    typedef struct packed {
        logic [0:0]  ch;
        logic [2:0]  eng;
        logic [31:0] x;
    } strobe_t;

    strobe_t slog [$];
    int      ack_cnt [N_ENG];

    always @(posedge clk) begin
        for (int e = 0; e < N_ENG; e++) begin
            if (eng_x_valid[e]) slog.push_back({eng_ch, 3'(e), eng_x});
            if (eng_y_ack[e])   ack_cnt[e]++;
        end
    end

    int          checks = 0;
    int          errors = 0;
    logic [47:0] sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        slog.delete();
        for (int e = 0; e < N_ENG; e++) ack_cnt[e] = 0;
    endtask

    task automatic start_frame(input logic [23:0] d0, input logic [23:0] d1,
                               input logic [2:0] bp, input logic [47:0] exp);
        @(negedge clk);
        data       = {d1, d0};
        bypass     = bp;
        data_valid = 1'b1;
        sb.push_back(exp);
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int start_cyc, input int lo,
                                input int hi, input bit data_on_ack);
        int          cyc;
        logic [47:0] exp;
        cyc = start_cyc;
        while (!filt_valid && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s latency=%0d", tag, cyc), 64'(cyc >= lo && cyc <= hi), 64'd1);
        if (sb.size() > 0) exp = sb.pop_front();
        else exp = 'x;
        check({tag, " data"}, 64'(filt_data), 64'(exp));
        filt_ack = 1'b1;
        if (data_on_ack) data_valid = 1'b1;
        @(negedge clk);
        filt_ack   = 1'b0;
        data_valid = 1'b0;
        check({tag, " valid drop"}, 64'(filt_valid), 64'd0);
    endtask

    typedef struct {
        logic [23:0] d0;
        logic [23:0] d1;
        logic [2:0]  bp;
        bit          fen;
        logic [31:0] fval;
        logic [23:0] e0;
        logic [23:0] e1;
    } vec_t;

    vec_t    vecs [6];
    strobe_t exp_q [$];
    strobe_t s;
    int      bad;
    int      lat;
    int      n1;

    initial begin
        vecs[0] = '{24'h7FFFFF, 24'h000010, 3'b000, 1'b0, 32'h0,        24'h7FFFFF, 24'h000010};
        vecs[1] = '{24'h800000, 24'hFFFFFF, 3'b010, 1'b0, 32'h0,        24'h800000, 24'hFFFFFF};
        vecs[2] = '{24'h123456, 24'hABCDEF, 3'b111, 1'b0, 32'h0,        24'h123456, 24'hABCDEF};
        vecs[3] = '{24'h000001, 24'h000002, 3'b000, 1'b1, 32'h7FFFFFC0, 24'h7FFFFF, 24'h7FFFFF};
        vecs[4] = '{24'h000003, 24'h000004, 3'b000, 1'b1, 32'h00000080, 24'h000001, 24'h000001};
        vecs[5] = '{24'h000005, 24'h000006, 3'b000, 1'b1, 32'hFFFFFF7F, 24'hFFFFFF, 24'hFFFFFF};

        repeat (3) @(negedge clk);
        check("reset outs A", 64'({filt_data, filt_valid, eng_ch, overrun, tmo}), 64'd0);
        check("reset outs B", 64'({eng_x, eng_x_valid, eng_y_ack}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            force_en  = vecs[i].fen;
            force_val = vecs[i].fval;
            clear_logs();
            lat = N_CH * 2 * (2 + N_FLT - $countones(vecs[i].bp));
            start_frame(vecs[i].d0, vecs[i].d1, vecs[i].bp, {vecs[i].e1, vecs[i].e0});
            finish_frame($sformatf("vec%0d", i), 0, lat, lat, 1'b0);
            exp_q.delete();
            for (int ch = 0; ch < N_CH; ch++) begin
                for (int e = 0; e < N_ENG; e++) begin
                    if (e == 0 || e == N_ENG - 1 || !vecs[i].bp[e-1]) begin
                        s.ch  = 1'(ch);
                        s.eng = 3'(e);
                        s.x   = 32'(ch == 0 ? vecs[i].d0 : vecs[i].d1) << 8;
                        exp_q.push_back(s);
                    end
                end
            end
            bad = (slog.size() == exp_q.size()) ? 0 : 1;
            if (bad == 0) begin
                for (int k = 0; k < exp_q.size(); k++) if (slog[k] != exp_q[k]) bad++;
            end
            check($sformatf("vec%0d strobe order", i), 64'(bad), 64'd0);
            n1 = 0;
            for (int e = 0; e < N_ENG; e++) n1 += ack_cnt[e];
            check($sformatf("vec%0d ack count", i), 64'(n1), 64'(exp_q.size()));
        end
        force_en = 1'b0;

        // Overrun during WAIT, clear, then error beating a same-cycle clear.
        clear_logs();
        start_frame(24'h000100, 24'hFFFF00, 3'b000, {24'hFFFF00, 24'h000100});
        bypass = 3'b111;
        @(negedge clk);
        data       = '1;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        check("overrun set", 64'(overrun), 64'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("overrun cleared", 64'(overrun), 64'd0);
        data_valid = 1'b1;
        err_clr    = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        err_clr    = 1'b0;
        check("overrun beats clear", 64'(overrun), 64'd1);
        finish_frame("ovr", 4, 20, 20, 1'b0);
        check("ovr bypass ignored", 64'(slog.size()), 64'd10);
        bypass = '0;

        // Engine 1 silent on channel 0: timeout, slot 0 zeroed, channel 1 normal.
        clear_logs();
        drop_mode = 1'b1;
        start_frame(24'h0ABCDE, 24'h135790, 3'b000, {24'h135790, 24'h000000});
        repeat (1000) @(negedge clk);
        check("timeout not early", 64'(tmo), 64'd0);
        finish_frame("tmo", 1000, TIMEOUT, TIMEOUT + 27, 1'b0);
        check("timeout flag", 64'(tmo), 64'd1);
        n1 = 0;
        foreach (slog[k]) if (slog[k].eng == 3'd1) n1++;
        check("tmo eng1 strobes", 64'(n1), 64'd2);
        check("tmo eng1 acks", 64'(ack_cnt[1]), 64'd1);
        drop_mode = 1'b0;

        // Reset while engine 0's result is pending in WAIT.
        clear_logs();
        @(negedge clk);
        data       = {24'h222222, 24'h111111};
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid rst outs A", 64'({filt_data, filt_valid, eng_ch, overrun, tmo}), 64'd0);
        check("mid rst outs B", 64'({eng_x, eng_x_valid, eng_y_ack}), 64'd0);
        check("mid rst no ack", 64'(ack_cnt[0]), 64'd0);
        check("mid rst strobes", 64'(slog.size()), 64'd1);

        // Fresh frame after reset; a frame offered on the ACK cycle is dropped.
        clear_logs();
        start_frame(24'h400000, 24'hC00000, 3'b000, {24'hC00000, 24'h400000});
        finish_frame("post rst", 0, 20, 20, 1'b1);
        check("ack cycle overrun", 64'(overrun), 64'd1);
        repeat (3) @(negedge clk);
        check("ack cycle frame dropped", 64'(slog.size()), 64'd10);
        check("idle after drop", 64'(filt_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
